// File: rtl/cnn_pkg.sv
// Shared CNN front-end types and constants.
// Pixel type plus 3x3 window index helper.
package cnn_pkg;

   localparam int DEF_WIDTH = 10;
   localparam int WIN       = 3;

   typedef logic signed [DEF_WIDTH-1:0] pix_t;

   // Flat index of window cell (column c, row r)
   function automatic int win_idx(int c, int r);
      return r * WIN + c;
   endfunction

endpackage

// File: rtl/window3x3_gen_if.sv
// Pixel-in / window-out handshake bundle for window3x3_gen.
// master drives pixels and out_ready, slave produces windows.
interface window3x3_gen_if
   import cnn_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] in_pix;
   logic                    out_valid;
   logic                    out_ready;
   logic                    out_last;
   logic signed [WIDTH-1:0] x_0_0, x_1_0, x_2_0;
   logic signed [WIDTH-1:0] x_0_1, x_1_1, x_2_1;
   logic signed [WIDTH-1:0] x_0_2, x_1_2, x_2_2;

   modport master (
      output in_valid, in_pix, out_ready,
      input  in_ready, out_valid, out_last,
      input  x_0_0, x_1_0, x_2_0,
      input  x_0_1, x_1_1, x_2_1,
      input  x_0_2, x_1_2, x_2_2
   );

   modport slave (
      input  in_valid, in_pix, out_ready,
      output in_ready, out_valid, out_last,
      output x_0_0, x_1_0, x_2_0,
      output x_0_1, x_1_1, x_2_1,
      output x_0_2, x_1_2, x_2_2
   );

endinterface

// File: rtl/line_delay.sv
// IMG_W-deep enable-gated pixel delay line.
// Async active-high clear.
module line_delay #(
   parameter int IMG_W = 28,
   parameter int WIDTH = 10
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] din,
   output logic signed [WIDTH-1:0] dout
);

   logic signed [WIDTH-1:0] sr [IMG_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < IMG_W; i++) sr[i] <= '0;
      end else if (en) begin
         sr[0] <= din;
         for (int i = 1; i < IMG_W; i++) sr[i] <= sr[i-1];
      end
   end

   assign dout = sr[IMG_W-1];

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator, valid convolution, no padding.
// Two line delays feed a 3x3 shift array behind one output register.
module window3x3_gen
   import cnn_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
)(
   input logic            clk,
   input logic            reset,
   window3x3_gen_if.slave s
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   typedef logic signed [WIDTH-1:0] wpix_t;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   wpix_t         w [WIN*WIN];
   wpix_t         l1_out;
   wpix_t         l2_out;
   logic          vld;
   logic          lst;
   logic          accept;
   logic          col_end;
   logic          row_end;
   logic          win_ok;

   assign s.in_ready = !vld || s.out_ready;
   assign accept     = s.in_valid && s.in_ready;
   assign col_end    = col == CW'(IMG_W-1);
   assign row_end    = row == RW'(IMG_H-1);
   assign win_ok     = (row >= RW'(2)) && (col >= CW'(2));

   line_delay #(.IMG_W(IMG_W), .WIDTH(WIDTH)) u_line1 (
      .clk   (clk),
      .reset (reset),
      .en    (accept),
      .din   (s.in_pix),
      .dout  (l1_out)
   );

   line_delay #(.IMG_W(IMG_W), .WIDTH(WIDTH)) u_line2 (
      .clk   (clk),
      .reset (reset),
      .en    (accept),
      .din   (l1_out),
      .dout  (l2_out)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Shifting continues across line wraps; only win_ok decides validity
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WIN*WIN; i++) w[i] <= '0;
      end else if (accept) begin
         for (int r = 0; r < WIN; r++) begin
            w[win_idx(0, r)] <= w[win_idx(1, r)];
            w[win_idx(1, r)] <= w[win_idx(2, r)];
         end
         w[win_idx(2, 0)] <= l2_out;
         w[win_idx(2, 1)] <= l1_out;
         w[win_idx(2, 2)] <= s.in_pix;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld <= 1'b0;
         lst <= 1'b0;
      end else if (accept) begin
         vld <= win_ok;
         lst <= win_ok && row_end && col_end;
      end else if (s.out_ready) begin
         vld <= 1'b0;
         lst <= 1'b0;
      end
   end

   assign s.out_valid = vld;
   assign s.out_last  = lst;

   assign s.x_0_0 = w[win_idx(0, 0)];
   assign s.x_1_0 = w[win_idx(1, 0)];
   assign s.x_2_0 = w[win_idx(2, 0)];
   assign s.x_0_1 = w[win_idx(0, 1)];
   assign s.x_1_1 = w[win_idx(1, 1)];
   assign s.x_2_1 = w[win_idx(2, 1)];
   assign s.x_0_2 = w[win_idx(0, 2)];
   assign s.x_1_2 = w[win_idx(1, 2)];
   assign s.x_2_2 = w[win_idx(2, 2)];

endmodule
